// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Shared UART definitions used by the receiver and the transmitter.
//   uart_state_e : receiver FSM state encoding
//   OVERSAMPLE   : oversample ticks per serial bit
//   DATA_W       : payload bits per frame
// ---------------------------------------------------------------------------
package uart_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } uart_state_e;

    localparam int OVERSAMPLE = 16;
    localparam int DATA_W     = 8;

endpackage

// File: rtl/uart_baud_gen.sv
// ---------------------------------------------------------------------------
// uart_baud_gen
// Oversample tick generator: a one-cycle pulse every DIV clocks while en is
// high. The counter is held at zero while en is low, so a new frame always
// starts with a full tick period.
//   clk_fpga : clock
//   rst_n    : asynchronous active-low reset
//   en       : run enable (receiver busy)
//   tick     : one-cycle oversample pulse
// ---------------------------------------------------------------------------
module uart_baud_gen #(
    parameter int DIV = 27
) (
    input  logic clk_fpga,
    input  logic rst_n,
    input  logic en,
    output logic tick
);

    localparam int                CNT_W  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0]  CNT_TC = CNT_W'(DIV - 1);

    if (DIV < 2) begin : g_bad_div
        $error("uart_baud_gen: DIV must be at least 2, got %0d", DIV);
    end

    logic [CNT_W-1:0] cnt_q;
    logic             tc;

    assign tc = (cnt_q == CNT_TC);

    always_ff @(posedge clk_fpga or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (!en || tc) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign tick = en && tc;

endmodule

// File: rtl/uart_rx.sv
// ---------------------------------------------------------------------------
// uart_rx
// 8N1 UART receiver with 16x oversampling and mid-bit sampling.
//   clk_fpga  : clock
//   rst_n     : asynchronous active-low reset
//   rx        : serial input, asynchronous, idle high
//   data      : last correctly framed byte
//   valid     : one-cycle pulse when data is updated
//   frame_err : one-cycle pulse when the stop bit samples low
//   busy      : high whenever the FSM is not idle
//
// state    | meaning
// ---------+---------------------------------------------------------------
// ST_IDLE  | waiting for a 1->0 edge on the synchronized line
// ST_START | counting to the middle of the start bit, rejecting glitches
// ST_DATA  | sampling 8 data bits LSB first, one per 16 ticks
// ST_STOP  | sampling the stop bit, then reporting byte or framing error
// ---------------------------------------------------------------------------
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLK_HZ = 50_000_000,
    parameter int BAUD   = 115200
) (
    input  logic              clk_fpga,
    input  logic              rst_n,
    input  logic              rx,
    output logic [DATA_W-1:0] data,
    output logic              valid,
    output logic              frame_err,
    output logic              busy
);

    localparam int DIV    = CLK_HZ / (BAUD * OVERSAMPLE);
    localparam int TICK_W = $clog2(OVERSAMPLE);
    localparam int BIT_W  = $clog2(DATA_W);

    localparam logic [TICK_W-1:0] TICK_MID  = TICK_W'(OVERSAMPLE / 2 - 1);
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(OVERSAMPLE - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_W - 1);

    logic rx_meta_q;
    logic rx_s_q;
    logic rx_prev_q;
    logic fall;
    logic tick;

    uart_state_e       state_q;
    logic [TICK_W-1:0] tick_cnt_q;
    logic [BIT_W-1:0]  bit_cnt_q;
    logic [DATA_W-1:0] shift_q;
    logic [DATA_W-1:0] data_q;
    logic              valid_q;
    logic              frame_err_q;

    // Synchronizer resets to the idle level so reset release never looks
    // like a start edge.
    always_ff @(posedge clk_fpga or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
            rx_prev_q <= 1'b1;
        end else begin
            rx_meta_q <= rx;
            rx_s_q    <= rx_meta_q;
            rx_prev_q <= rx_s_q;
        end
    end

    // Edge rather than level: a line held low (e.g. after a framing error)
    // must return high before another frame can start.
    assign fall = rx_prev_q && !rx_s_q;

    uart_baud_gen #(
        .DIV (DIV)
    ) u_baud_gen (
        .clk_fpga (clk_fpga),
        .rst_n    (rst_n),
        .en       (busy),
        .tick     (tick)
    );

    always_ff @(posedge clk_fpga or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            tick_cnt_q  <= '0;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            data_q      <= '0;
            valid_q     <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            valid_q     <= 1'b0;
            frame_err_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    tick_cnt_q <= '0;
                    bit_cnt_q  <= '0;
                    if (fall) begin
                        state_q <= ST_START;
                    end
                end
                ST_START: begin
                    if (tick) begin
                        if (tick_cnt_q == TICK_MID) begin
                            tick_cnt_q <= '0;
                            state_q    <= rx_s_q ? ST_IDLE : ST_DATA;
                        end else begin
                            tick_cnt_q <= tick_cnt_q + 1'b1;
                        end
                    end
                end
                ST_DATA: begin
                    if (tick) begin
                        if (tick_cnt_q == TICK_LAST) begin
                            tick_cnt_q <= '0;
                            shift_q    <= {rx_s_q, shift_q[DATA_W-1:1]};
                            if (bit_cnt_q == BIT_LAST) begin
                                bit_cnt_q <= '0;
                                state_q   <= ST_STOP;
                            end else begin
                                bit_cnt_q <= bit_cnt_q + 1'b1;
                            end
                        end else begin
                            tick_cnt_q <= tick_cnt_q + 1'b1;
                        end
                    end
                end
                ST_STOP: begin
                    if (tick) begin
                        if (tick_cnt_q == TICK_LAST) begin
                            tick_cnt_q <= '0;
                            state_q    <= ST_IDLE;
                            if (rx_s_q) begin
                                data_q  <= shift_q;
                                valid_q <= 1'b1;
                            end else begin
                                frame_err_q <= 1'b1;
                            end
                        end else begin
                            tick_cnt_q <= tick_cnt_q + 1'b1;
                        end
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign data      = data_q;
    assign valid     = valid_q;
    assign frame_err = frame_err_q;
    assign busy      = (state_q != ST_IDLE);

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter CLK_HZ, default 50_000_000, is the clk_fpga frequency in Hz.
REQ-002 Parameter BAUD, default 115200, is the serial bit rate.
REQ-003 Port clk_fpga, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 Port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 Port rx, input, 1 bit: serial line, asynchronous to clk_fpga, idle high.
REQ-006 Port data, output, 8 bits: last correctly framed byte.
REQ-007 Port valid, output, 1 bit: one-cycle pulse when data is updated.
REQ-008 Port frame_err, output, 1 bit: one-cycle pulse when the stop bit samples low.
REQ-009 Port busy, output, 1 bit: high whenever the FSM is not in IDLE.

Function
REQ-010 The rx input SHALL pass through a 2-flop synchronizer; all later logic uses only the synchronized value rx_s.
REQ-011 An oversample tick SHALL be generated every DIV = CLK_HZ/(BAUD*16) clocks (integer truncation), as a 1-cycle pulse; DIV < 2 SHALL be a elaboration error.
REQ-012 The tick divider SHALL free-run only while busy, and SHALL reload to 0 on the IDLE->START transition.
REQ-013 FSM states: IDLE, START, DATA, STOP.
REQ-014 IDLE: a falling edge on rx_s (previous 1, current 0) SHALL move to START; a line stuck low SHALL NOT start a frame.
REQ-015 START: after 8 ticks rx_s is sampled; 0 -> DATA with tick count cleared; 1 -> IDLE (glitch rejection), no pulse.
REQ-016 DATA: every 16 ticks one bit is sampled, LSB first, into an 8-bit shift register; after bit 7 -> STOP.
REQ-017 STOP: after 16 ticks rx_s is sampled; 1 -> data loaded from the shift register and valid pulsed; 0 -> frame_err pulsed and data unchanged; either way -> IDLE in the same cycle.
REQ-018 valid and frame_err SHALL never be high in the same cycle and SHALL each be high for exactly one clk_fpga cycle per frame.
REQ-019 data SHALL hold its value between valid pulses; no consumer handshake exists and a new frame overwrites it.
REQ-020 After a framing error, a new frame SHALL be accepted only after rx_s has been seen high (this follows from the edge rule in REQ-014).
REQ-021 Back-to-back frames (start bit immediately after the stop bit) SHALL be received without loss, because sampling occurs mid-stop-bit.
REQ-022 Bit and tick counters SHALL be sized by $clog2 of their terminal values; no counter wraps inside a state.

Reset
REQ-023 While rst_n is low: FSM = IDLE, data = 8'h00, valid = 0, frame_err = 0, busy = 0, synchronizer flops = 1, counters = 0.
REQ-024 Reset asserted mid-frame SHALL abort the frame with no valid or frame_err pulse; after release the first complete frame is received normally.

Structure
REQ-025 Shared package uart_pkg SHALL hold the FSM state enum, OVERSAMPLE = 16, and the data width of 8 (shared with the transmitter).
REQ-026 The tick generator SHALL be a sub-module uart_baud_gen with parameter DIV and ports clk_fpga, rst_n, en and tick.

Verification (CLK_HZ = 50_000_000, BAUD = 115200, DIV = 27, bit = 432 clks)
REQ-027 Frame 8'hA5 with a good stop bit -> valid pulses once, data = 8'hA5, frame_err = 0, valid occurs about 9.5 bits after the start edge (+-1 tick + 2 sync clocks).
REQ-028 Frame 8'h3C with the stop bit driven low -> frame_err pulses once, no valid, data keeps its previous value.
REQ-029 A 100-clock low glitch on an idle line -> returns to IDLE, no valid, no frame_err, busy falls within 8 ticks.
REQ-030 Three back-to-back frames 8'h00, 8'hFF, 8'h55 -> three valid pulses with matching data, in order.
REQ-031 rst_n pulsed low during bit 4 of a frame, then frame 8'h81 sent -> no pulse for the aborted frame, then valid with data = 8'h81.
REQ-032 Bit timing skewed +-3% on the input frame 8'hC3 -> received correctly.
